// File: rtl/alpctl_pkg.sv
// Shared types and opcode constants for the ALPCTL issue path.
// Commands are turned into opcodes at accept time, so the queue only carries opcodes.
package alpctl_pkg;

  localparam int OPC_W    = 10;
  localparam int ALP_REPW = 4;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_DMOVE_LD   = 3'd1,
    CMD_DMOVE_NOLD = 3'd2,
    CMD_PASS_A     = 3'd3,
    CMD_WMUX_OFF   = 3'd4,
    CMD_RAW        = 3'd5
  } alp_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } iss_state_e;

  localparam logic [OPC_W-1:0] OPC_NOP        = 10'h000;
  localparam logic [OPC_W-1:0] OPC_DMOVE_LD   = 10'h057;
  localparam logic [OPC_W-1:0] OPC_DMOVE_NOLD = 10'h047;
  localparam logic [OPC_W-1:0] OPC_PASS_A     = 10'h24A;
  localparam logic [OPC_W-1:0] OPC_WMUX_OFF   = 10'h260;

  typedef struct packed {
    logic [OPC_W-1:0]    opc;
    logic [ALP_REPW-1:0] rep;
  } fifo_entry_t;

  // Codes 6 and 7 have no fixed decode; they are queued as NOP and flagged.
  function automatic logic cmd_illegal(input logic [2:0] cmd);
    return cmd > CMD_RAW;
  endfunction

  function automatic logic [OPC_W-1:0] cmd_to_opc(input logic [2:0] cmd,
                                                   input logic [OPC_W-1:0] raw);
    logic [OPC_W-1:0] opc;
    case (cmd)
      CMD_DMOVE_LD:   opc = OPC_DMOVE_LD;
      CMD_DMOVE_NOLD: opc = OPC_DMOVE_NOLD;
      CMD_PASS_A:     opc = OPC_PASS_A;
      CMD_WMUX_OFF:   opc = OPC_WMUX_OFF;
      CMD_RAW:        opc = raw;
      default:        opc = OPC_NOP;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/alpctl_cmd_fifo.sv
// Small synchronous FIFO for encoded ALPCTL commands.
// Full/empty come from an occupancy count; writes when full and reads when empty are ignored.
module alpctl_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 14
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             push_h,
  input  logic [WIDTH-1:0] din_h,
  input  logic             pop_h,
  output logic [WIDTH-1:0] head_h,
  output logic             full_h,
  output logic             empty_h
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_h  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_h = (cnt_q == '0);
  assign do_push = push_h & ~full_h;
  assign do_pop  = pop_h & ~empty_h;
  assign head_h  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_h) begin
    if (do_push) mem_q[wr_q] <= din_h;
  end

endmodule

// File: rtl/alpctl_issue.sv
// ALPCTL opcode issuer: queues microsequencer commands and drives one opcode per cycle,
// holding each for rep+1 non-stalled cycles with back-to-back commands issued without a NOP gap.
module alpctl_issue
  import alpctl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REPW  = ALP_REPW
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             cmd_valid_h,
  output logic             cmd_ready_h,
  input  logic [2:0]       cmd_h,
  input  logic [REPW-1:0]  rep_h,
  input  logic [OPC_W-1:0] raw_h,
  input  logic             stall_h,
  output logic [OPC_W-1:0] opc_h,
  output logic             busy_h,
  output logic             last_h,
  output logic             err_h
);

  localparam int EW = OPC_W + REPW;

  iss_state_e       state_q, state_d;
  logic [REPW-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             err_q;
  logic             accept, load;
  logic             fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_din, fifo_head;

  assign cmd_ready_h = ~fifo_full;
  assign accept      = cmd_valid_h & cmd_ready_h;
  assign fifo_din    = {cmd_to_opc(cmd_h, raw_h), rep_h};

  alpctl_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .push_h  (accept),
    .din_h   (fifo_din),
    .pop_h   (load),
    .head_h  (fifo_head),
    .full_h  (fifo_full),
    .empty_h (fifo_empty)
  );

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opc_q   <= OPC_NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      err_q   <= err_q | (accept & cmd_illegal(cmd_h));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        opc_d = OPC_NOP;
        if (!fifo_empty && !stall_h) load = 1'b1;
      end
      ST_ISSUE: begin
        if (!stall_h) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - REPW'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            opc_d   = OPC_NOP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Popping the head and loading it share one edge, which is what removes the bubble.
    if (load) begin
      state_d = ST_ISSUE;
      opc_d   = fifo_head[EW-1:REPW];
      cnt_d   = fifo_head[REPW-1:0];
    end
  end

  always_comb begin
    opc_h  = opc_q;
    err_h  = err_q;
    busy_h = (state_q == ST_ISSUE) | ~fifo_empty;
    last_h = (state_q == ST_ISSUE) & (cnt_q == '0);
  end

endmodule

// File: tb/tb_alpctl_issue.sv
// Directed bench for alpctl_issue with hand-computed opcode sequences.
module tb_alpctl_issue;

  logic       clk_h = 1'b0;
  logic       reset_h;
  logic       cmd_valid_h;
  logic       cmd_ready_h;
  logic [2:0] cmd_h;
  logic [3:0] rep_h;
  logic [9:0] raw_h;
  logic       stall_h;
  logic [9:0] opc_h;
  logic       busy_h, last_h, err_h;

  int n_cmp = 0;
  int n_bad = 0;

  alpctl_issue #(.DEPTH(2), .REPW(4)) dut (
    .clk_h       (clk_h),
    .reset_h     (reset_h),
    .cmd_valid_h (cmd_valid_h),
    .cmd_ready_h (cmd_ready_h),
    .cmd_h       (cmd_h),
    .rep_h       (rep_h),
    .raw_h       (raw_h),
    .stall_h     (stall_h),
    .opc_h       (opc_h),
    .busy_h      (busy_h),
    .last_h      (last_h),
    .err_h       (err_h)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [3:0] r, input logic [9:0] w);
    cmd_valid_h = 1'b1;
    cmd_h       = c;
    rep_h       = r;
    raw_h       = w;
    tick();
    cmd_valid_h = 1'b0;
  endtask

  initial begin
    logic [9:0] seq[$];
    logic [9:0] prev;
    logic [9:0] exp_seq[5];
    logic       rdy;
    int         n24a, n057, nlast;

    reset_h = 1'b1; cmd_valid_h = 1'b0; cmd_h = '0; rep_h = '0; raw_h = '0; stall_h = 1'b0;
    tick(); tick();
    reset_h = 1'b0;
    tick();
    chk_eq("rst_opc",   16'(opc_h), 16'h000);
    chk_eq("rst_ready", 16'(cmd_ready_h), 16'h1);
    chk_eq("rst_busy",  16'(busy_h), 16'h0);
    chk_eq("rst_last",  16'(last_h), 16'h0);
    chk_eq("rst_err",   16'(err_h), 16'h0);

    // Reset while DMOVE_LD rep=5 is being issued
    push(3'd1, 4'd5, 10'h0);
    tick();
    chk_eq("inflight_opc", 16'(opc_h), 16'h057);
    tick();
    reset_h = 1'b1;
    #1;
    chk_eq("abort_opc",  16'(opc_h), 16'h000);
    chk_eq("abort_busy", 16'(busy_h), 16'h0);
    chk_eq("abort_err",  16'(err_h), 16'h0);
    tick();
    reset_h = 1'b0;
    tick();
    chk_eq("abort_idle_opc", 16'(opc_h), 16'h000);

    // PASS_A rep=0: one cycle of 24A with last_h
    push(3'd3, 4'd0, 10'h0);
    chk_eq("pa_lat_opc", 16'(opc_h), 16'h000);
    chk_eq("pa_lat_busy", 16'(busy_h), 16'h1);
    tick();
    chk_eq("pa_opc",  16'(opc_h), 16'h24A);
    chk_eq("pa_last", 16'(last_h), 16'h1);
    tick();
    chk_eq("pa_end_opc",  16'(opc_h), 16'h000);
    chk_eq("pa_end_last", 16'(last_h), 16'h0);
    chk_eq("pa_end_busy", 16'(busy_h), 16'h0);

    // Back-to-back DMOVE_NOLD rep=2 then WMUX_OFF rep=0
    push(3'd2, 4'd2, 10'h0);
    push(3'd4, 4'd0, 10'h0);
    chk_eq("b2b_c1_opc", 16'(opc_h), 16'h047); chk_eq("b2b_c1_last", 16'(last_h), 16'h0);
    tick();
    chk_eq("b2b_c2_opc", 16'(opc_h), 16'h047); chk_eq("b2b_c2_last", 16'(last_h), 16'h0);
    tick();
    chk_eq("b2b_c3_opc", 16'(opc_h), 16'h047); chk_eq("b2b_c3_last", 16'(last_h), 16'h1);
    tick();
    chk_eq("b2b_c4_opc", 16'(opc_h), 16'h260); chk_eq("b2b_c4_last", 16'(last_h), 16'h1);
    tick();
    chk_eq("b2b_c5_opc", 16'(opc_h), 16'h000); chk_eq("b2b_c5_last", 16'(last_h), 16'h0);

    // Fill: one active plus two queued, a fourth command waits for space
    push(3'd1, 4'd7, 10'h0);
    push(3'd3, 4'd7, 10'h0);
    push(3'd4, 4'd7, 10'h0);
    chk_eq("fill_ready", 16'(cmd_ready_h), 16'h0);
    cmd_valid_h = 1'b1; cmd_h = 3'd2; rep_h = 4'd7;
    seq.push_back(opc_h);
    prev = opc_h;
    n24a = 0;
    for (int i = 0; i < 60; i++) begin
      rdy = cmd_ready_h;
      tick();
      if (cmd_valid_h && rdy) cmd_valid_h = 1'b0;
      if (opc_h == 10'h24A) n24a++;
      if (opc_h != prev) seq.push_back(opc_h);
      prev = opc_h;
    end
    chk_eq("fill_held_dropped", 16'(cmd_valid_h), 16'h0);
    exp_seq = '{10'h057, 10'h24A, 10'h260, 10'h047, 10'h000};
    chk_eq("fill_seq_len", 16'(seq.size()), 16'd5);
    for (int i = 0; i < 5; i++)
      chk_eq($sformatf("fill_seq%0d", i), (i < seq.size()) ? 16'(seq[i]) : 16'hFFFF, 16'(exp_seq[i]));
    chk_eq("fill_24a_cycles", 16'(n24a), 16'd8);

    // Stall 4 cycles during DMOVE_LD rep=3
    push(3'd1, 4'd3, 10'h0);
    n057 = 0; nlast = 0;
    for (int i = 0; i < 12; i++) begin
      stall_h = (i >= 1 && i <= 4);
      tick();
      if (opc_h == 10'h057) n057++;
      if (last_h) nlast++;
      if (i == 4) chk_eq("stall_hold_last", 16'(last_h), 16'h0);
    end
    stall_h = 1'b0;
    chk_eq("stall_057_cycles", 16'(n057), 16'd8);
    chk_eq("stall_last_cycles", 16'(nlast), 16'd1);

    // Illegal code 6 followed by RAW 3FF
    push(3'd6, 4'd0, 10'h0);
    push(3'd5, 4'd0, 10'h3FF);
    chk_eq("ill_err", 16'(err_h), 16'h1);
    chk_eq("ill_opc", 16'(opc_h), 16'h000);
    chk_eq("ill_busy", 16'(busy_h), 16'h1);
    tick();
    chk_eq("raw_opc", 16'(opc_h), 16'h3FF);
    chk_eq("raw_last", 16'(last_h), 16'h1);
    tick();
    chk_eq("raw_end_opc", 16'(opc_h), 16'h000);
    chk_eq("raw_end_busy", 16'(busy_h), 16'h0);
    chk_eq("err_sticky", 16'(err_h), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
